rob_alloc: RTL and testbench

ROB entry allocator for the dispatch stage: it hands out ROB entry addresses to up to two dispatching instructions per cycle and reclaims entries as the ROB commits them. It keeps the tail pointer and the free-entry count, asserts stall when the ROB cannot accept a dispatch group, and rolls the tail back to the commit point on a pipeline flush. It drives the ROB's dispatch strobe and address inputs and consumes the ROB's commit signal and commit pointer.

---
 rtl/rob_alloc_pkg.sv | 15 +
 rtl/rob_alloc.sv | 92 +++++++++
 tb/tb_rob_alloc.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rob_alloc_pkg.sv
// Shared constants and helpers for the ROB entry allocator.
package rob_alloc_pkg;

  // Default ROB geometry; ROB_NUM must stay a power of two so that
  // pointer arithmetic can simply drop the carry bit.
  localparam int DEF_ROB_NUM = 64;
  localparam int DEF_ROB_SEL = 6;

  // Number of entries a dispatch group asks for. Slot 2 only counts
  // when slot 1 is also requesting.
  function automatic logic [1:0] req_count(input logic req1, input logic req2);
    return {1'b0, req1} + {1'b0, req1 & req2};
  endfunction

endpackage

// File: rtl/rob_alloc.sv
// ROB entry allocator: hands out up to two ROB addresses per cycle,
// tracks the free-entry count, and rewinds the tail on a flush.
module rob_alloc
  import rob_alloc_pkg::*;
#(
  parameter int ROB_NUM = DEF_ROB_NUM,
  parameter int ROB_SEL = DEF_ROB_SEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req1_i,
  input  logic               req2_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               commit_1_i,
  input  logic [ROB_SEL-1:0] commit_ptr_i,
  output logic               dp1_o,
  output logic               dp2_o,
  output logic [ROB_SEL-1:0] dp1_addr_o,
  output logic [ROB_SEL-1:0] dp2_addr_o,
  output logic               alloc_stall_o,
  output logic [ROB_SEL:0]   freenum_o,
  output logic [ROB_SEL-1:0] tail_o
);

  localparam int CW = ROB_SEL + 1;
  localparam logic [CW-1:0] EMPTY_CNT = CW'(ROB_NUM);

  logic [ROB_SEL-1:0] tail;
  logic [ROB_SEL-1:0] tail_nxt;
  logic [CW-1:0]      freenum;
  logic [CW-1:0]      freenum_nxt;
  logic [1:0]         n_req;
  logic [1:0]         n_grant;
  logic               grant;
  logic               commit_eff;
  logic               short;

  // Grant decision and next-state computation from registered state.
  // NOTE: every variable gets a default first so no path can leave one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    n_req       = req_count(req1_i, req2_i);
    short       = freenum < CW'(n_req);
    grant       = 1'b0;
    n_grant     = 2'd0;
    commit_eff  = 1'b0;
    tail_nxt    = tail;
    freenum_nxt = freenum;

    // All-or-nothing: a two-wide group is never split. A commit this
    // cycle does not help, the check sees only the registered count.
    grant   = (n_req != 2'd0) && !stall_i && !flush_i && !short;
    n_grant = grant ? n_req : 2'd0;

    // A commit with every entry already free is a protocol error; the
    // count saturates at ROB_NUM instead of overflowing.
    commit_eff = commit_1_i && (freenum != EMPTY_CNT);

    if (flush_i) begin
      // Everything past the commit point is squashed.
      tail_nxt    = commit_ptr_i + ROB_SEL'(commit_1_i);
      freenum_nxt = EMPTY_CNT;
    end else begin
      tail_nxt    = tail + ROB_SEL'(n_grant);
      freenum_nxt = freenum - CW'(n_grant) + CW'(commit_eff);
    end
  end

  // Tail pointer and free count registers.
  // NOTE: sequential state uses non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tail    <= '0;
      freenum <= EMPTY_CNT;
    end else begin
      tail    <= tail_nxt;
      freenum <= freenum_nxt;
    end
  end

  // Outputs are combinational so allocation has zero-cycle latency.
  assign dp1_o         = grant && req1_i;
  assign dp2_o         = grant && req1_i && req2_i;
  assign dp1_addr_o    = tail;
  assign dp2_addr_o    = tail + ROB_SEL'(1);
  assign alloc_stall_o = (n_req != 2'd0) && !flush_i && short;
  assign freenum_o     = freenum;
  assign tail_o        = tail;

endmodule

// File: tb/tb_rob_alloc.sv
// Scoreboard bench for rob_alloc: the driver queues expected outputs
// with each directed vector; a negedge monitor pops and compares.
module tb_rob_alloc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req1_i = 1'b0, req2_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
  logic       commit_1_i = 1'b0;
  logic [5:0] commit_ptr_i = '0;
  logic       dp1_o, dp2_o, alloc_stall_o;
  logic [5:0] dp1_addr_o, dp2_addr_o, tail_o;
  logic [6:0] freenum_o;

  typedef struct {
    logic [27:0] vec;   // {dp1, dp2, a1, a2, stall, free, tail}
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic vec_valid = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  rob_alloc #(.ROB_NUM(64), .ROB_SEL(6)) dut (
    .clk(clk), .reset(reset),
    .req1_i(req1_i), .req2_i(req2_i), .stall_i(stall_i), .flush_i(flush_i),
    .commit_1_i(commit_1_i), .commit_ptr_i(commit_ptr_i),
    .dp1_o(dp1_o), .dp2_o(dp2_o),
    .dp1_addr_o(dp1_addr_o), .dp2_addr_o(dp2_addr_o),
    .alloc_stall_o(alloc_stall_o), .freenum_o(freenum_o), .tail_o(tail_o)
  );

  always #5 clk = ~clk;

  // Protocol checks on the stimulus the bench itself drives.
  always @(posedge clk) begin
    if (reset) begin
      assert (!(req2_i && !req1_i)) else $error("req2_i without req1_i");
      assert (!(commit_1_i && !flush_i && freenum_o == 7'd64))
        else $error("commit with all entries free");
    end
  end

  // Monitor: compares DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (vec_valid) begin
      logic [27:0] act;
      act = {dp1_o, dp2_o, dp1_addr_o, dp2_addr_o, alloc_stall_o, freenum_o, tail_o};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL no_expectation: got %h, required a queued vector", act);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (act !== e.vec) begin
          n_miss++;
          $display("FAIL %s: got dp=%b%b a1=%0d a2=%0d st=%b free=%0d tail=%0d, required dp=%b%b a1=%0d a2=%0d st=%b free=%0d tail=%0d",
                   e.name, act[27], act[26], act[25:20], act[19:14], act[13], act[12:6], act[5:0],
                   e.vec[27], e.vec[26], e.vec[25:20], e.vec[19:14], e.vec[13], e.vec[12:6], e.vec[5:0]);
        end
      end
    end
  end

  // Drive one vector after the edge and queue what the DUT must show.
  task automatic apply(input string name, input logic rst, input logic r1, input logic r2,
                       input logic st, input logic fl, input logic cm, input int cp,
                       input logic e_dp1, input logic e_dp2, input int e_a1, input int e_a2,
                       input logic e_st, input int e_fr, input int e_tl);
    exp_t e;
    @(posedge clk);
    #1;
    reset        = rst;
    req1_i       = r1;
    req2_i       = r2;
    stall_i      = st;
    flush_i      = fl;
    commit_1_i   = cm;
    commit_ptr_i = 6'(cp);
    e.vec  = {e_dp1, e_dp2, 6'(e_a1), 6'(e_a2), e_st, 7'(e_fr), 6'(e_tl)};
    e.name = name;
    exp_q.push_back(e);
    vec_valid = 1'b1;
  endtask

  initial begin
    #12 reset = 1'b1;

    // Reset state, no requests.
    apply("reset_idle", 1, 0,0,0,0,0,0,  0,0, 0,1, 0, 64, 0);

    // Fill the ROB two at a time: addresses 0..63 in pairs.
    for (int i = 0; i < 32; i++)
      apply("fill_pair", 1, 1,1,0,0,0,0,  1,1, 2*i, 2*i+1, 0, 64-2*i, 2*i);
    apply("full_pair_stall", 1, 1,1,0,0,0,0,  0,0, 0,1, 1, 0, 0);
    apply("full_single_stall", 1, 1,0,0,0,0,0,  0,0, 0,1, 1, 0, 0);

    // Flush to tail 8, then allocate down to tail 63 with 10 free.
    apply("flush_to_8", 1, 0,0,0,1,0,8,  0,0, 0,1, 0, 0, 0);
    for (int i = 0; i < 27; i++)
      apply("refill_pair", 1, 1,1,0,0,0,0,  1,1, 8+2*i, 9+2*i, 0, 64-2*i, 8+2*i);
    apply("single_with_commit", 1, 1,0,0,0,1,0,  1,0, 62,63, 0, 10, 62);

    // Wrap-around of the pair addresses.
    apply("wrap_pair", 1, 1,1,0,0,0,0,  1,1, 63,0, 0, 10, 63);
    apply("after_wrap", 1, 0,0,0,0,0,0,  0,0, 1,2, 0, 8, 1);

    // Drain to one free entry.
    apply("drain_a", 1, 1,1,0,0,0,0,  1,1, 1,2, 0, 8, 1);
    apply("drain_b", 1, 1,1,0,0,0,0,  1,1, 3,4, 0, 6, 3);
    apply("drain_c", 1, 1,1,0,0,0,0,  1,1, 5,6, 0, 4, 5);
    apply("drain_d", 1, 1,0,0,0,0,0,  1,0, 7,8, 0, 2, 7);

    // One free: a same-cycle commit does not enable the pair.
    apply("one_free_commit", 1, 1,1,0,0,1,0,  0,0, 8,9, 1, 1, 8);
    apply("two_free_grant", 1, 1,1,0,0,0,0,  1,1, 8,9, 0, 2, 8);

    // Flush with requests active: no strobes, no stall, tail to 21.
    apply("flush_with_req", 1, 1,1,0,1,1,20,  0,0, 10,11, 0, 0, 10);
    apply("after_flush", 1, 0,0,0,0,0,0,  0,0, 21,22, 0, 64, 21);

    // Allocate 59 entries to reach five free at tail 16.
    for (int i = 0; i < 29; i++)
      apply("to_five_pair", 1, 1,1,0,0,0,0,  1,1, (21+2*i)%64, (22+2*i)%64, 0, 64-2*i, (21+2*i)%64);
    apply("to_five_single", 1, 1,0,0,0,0,0,  1,0, 15,16, 0, 6, 15);

    // Downstream hold: no strobes, no alloc stall, commit still counts.
    apply("stall_in_commit", 1, 1,1,1,0,1,0,  0,0, 16,17, 0, 5, 16);
    apply("after_stall_in", 1, 0,0,0,0,0,0,  0,0, 16,17, 0, 6, 16);

    // Reset pulled mid-cycle takes effect before any clock edge.
    apply("async_reset", 0, 0,0,0,0,0,0,  0,0, 0,1, 0, 64, 0);
    apply("reset_release", 1, 0,0,0,0,0,0,  0,0, 0,1, 0, 64, 0);
    apply("post_reset_pair", 1, 1,1,0,0,0,0,  1,1, 0,1, 0, 64, 0);
    apply("post_reset_state", 1, 0,0,0,0,0,0,  0,0, 2,3, 0, 62, 2);

    @(posedge clk);
    #1 vec_valid = 1'b0;
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL leftover: got %0d unchecked vectors, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion, required summary before 100000");
    $fatal(1, "timeout");
  end

endmodule
